regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file between NUM_REQ write-back sources (index 0 = ALU, 1 = load unit, 2 = mult/div).
- Round-robin arbitration with a valid/ready handshake per requester, plus an atomic multi-beat lock so that a multi-register result is written back-to-back.
- Drives registered we/waddr/wdata into the register file. The arbiter updates on the rising edge; the register file captures on the following falling edge.

---
 rtl/regfile_pkg.sv | 35 +++
 rtl/regfile_wb_arbiter_if.sv | 33 +++
 rtl/rr_pick.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file write-back arbiter slice:
// register-file geometry, arbiter state encoding, requester index names
// and the round-robin pointer wrap helper.
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Width of requester indices, pointer and owner (covers NUM_REQ up to 8).
    localparam int IDX_W = 3;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_MDU  = 2;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Next requester after idx, wrapping at n so that pointer values >= n
    // never occur even when n is not a power of two.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                  input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Write-back request bus between NUM_REQ requesters and the arbiter.
//   req_valid [NUM_REQ]        per-requester request valid
//   req_addr  [5*NUM_REQ]      destination register, slice i = [5i+4:5i]
//   req_data  [32*NUM_REQ]     write data, slice i = [32i+31:32i]
//   req_last  [NUM_REQ]        1 = final/only beat, 0 = more beats under lock
//   req_ready [NUM_REQ]        one-hot grant from the arbiter
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [REG_ADDR_W*NUM_REQ-1:0] req_addr;
    logic [REG_DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;

    modport master (
        output req_valid, req_addr, req_data, req_last,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_last,
        output req_ready
    );

endinterface

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches valid starting at ptr and
// wrapping at NUM_REQ; returns the first hit as a one-hot grant plus its
// encoded index.
//   valid [NUM_REQ]  request vector
//   ptr   [3]        search start (always < NUM_REQ)
//   grant [NUM_REQ]  one-hot winner, zero when nothing is valid
//   idx   [3]        encoded winner, zero when nothing is valid
// ---------------------------------------------------------------------------
module rr_pick
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic found;
    int   cand;

    // NOTE: every variable written here gets a default first, so no path
    // through the loops can leave a value held and infer a latch.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            // Constant-index scan keeps every bit select statically sized.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && valid[i] && (i == cand)) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    idx      = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register-file write port between NUM_REQ write-back
// sources with round-robin arbitration and an atomic multi-beat lock.
//   clk        system clock, rising-edge state updates
//   rst        synchronous active-low reset
//   bus        request bus (slave modport): valid/addr/data/last in, ready out
//   we         registered write enable (never set for register $0)
//   waddr      registered write address
//   wdata      registered write data
//   owner      index of the last granted requester
//   locked     1 while a burst holds the lock
//   burst_err  one-cycle pulse when a burst is force-released at MAX_BURST
// The register file captures we/waddr/wdata on the falling edge that
// follows the rising edge that registered them.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [REG_DATA_W-1:0] wdata,
    output logic [IDX_W-1:0]      owner,
    output logic                  locked,
    output logic                  burst_err
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    logic                  we_d, err_d;
    logic [REG_ADDR_W-1:0] waddr_d;
    logic [REG_DATA_W-1:0] wdata_d;
    logic [IDX_W-1:0]      owner_d;

    logic [NUM_REQ-1:0]    pick_grant;
    logic [IDX_W-1:0]      pick_idx;
    logic [NUM_REQ-1:0]    ready;
    logic                  fire;
    logic [IDX_W-1:0]      g;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [REG_DATA_W-1:0] sel_data;
    logic                  sel_last;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid (bus.req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Grant. During LOCK only the lock holder (which is always the last
    // granted requester, i.e. owner) may transfer.
    always_comb begin
        ready = '0;
        if (rst) begin
            if (state_q == ARB) begin
                ready = pick_grant;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    ready[i] = bus.req_valid[i] && (owner == IDX_W'(i));
                end
            end
        end
    end

    assign bus.req_ready = ready;
    assign fire          = |(ready & bus.req_valid);
    assign g             = (state_q == ARB) ? pick_idx : owner;
    assign cnt_inc       = cnt_q + CNT_W'(1);

    // Payload of the granted requester.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g == IDX_W'(i)) begin
                sel_addr = bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = bus.req_data[i*REG_DATA_W +: REG_DATA_W];
                sel_last = bus.req_last[i];
            end
        end
    end

    // Next state and next outputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = waddr;
        wdata_d = wdata;
        owner_d = owner;
        err_d   = 1'b0;

        if (fire) begin
            // $0 beats are consumed like any other but never written.
            we_d    = (sel_addr != REG_ZERO);
            waddr_d = sel_addr;
            wdata_d = sel_data;
            owner_d = g;

            if (state_q == ARB) begin
                if (sel_last) begin
                    ptr_d = wrap_inc(g, NUM_REQ);
                end else if (MAX_BURST <= 1) begin
                    ptr_d = wrap_inc(g, NUM_REQ);
                    err_d = 1'b1;
                end else begin
                    state_d = LOCK;
                    cnt_d   = CNT_W'(1);
                end
            end else begin
                if (sel_last || (cnt_inc == CNT_W'(MAX_BURST))) begin
                    state_d = ARB;
                    ptr_d   = wrap_inc(owner, NUM_REQ);
                    cnt_d   = '0;
                    err_d   = !sel_last;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ARB;
            ptr_q     <= IDX_W'(REQ_ALU);
            cnt_q     <= '0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            owner     <= '0;
            locked    <= 1'b0;
            burst_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            we        <= we_d;
            waddr     <= waddr_d;
            wdata     <= wdata_d;
            owner     <= owner_d;
            locked    <= (state_d == LOCK);
            burst_err <= err_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter (NUM_REQ=3, MAX_BURST=4).
// Each cycle a test drives requests, checks req_ready combinationally and
// pushes the outputs it expects after the next rising edge; advance() pops
// and compares them one time unit after that edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 3;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  owner;
        logic        locked;
        logic        err;
        logic        chk_wr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  owner;
    logic        locked;
    logic        burst_err;

    exp_t sb[$];
    int   n_checks;
    int   n_pass;

    regfile_wb_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(NREQ), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .owner     (owner),
        .locked    (locked),
        .burst_err (burst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic v, input logic [4:0] a,
                           input logic [31:0] d, input logic l);
        bus.req_valid[i]         = v;
        bus.req_addr[i*5 +: 5]   = a;
        bus.req_data[i*32 +: 32] = d;
        bus.req_last[i]          = l;
    endtask

    task automatic push_exp(input logic e_we, input logic [4:0] a, input logic [31:0] d,
                            input logic [2:0] o, input logic lk, input logic er,
                            input logic chk);
        exp_t e;
        e.we = e_we; e.waddr = a; e.wdata = d; e.owner = o;
        e.locked = lk; e.err = er; e.chk_wr = chk;
        sb.push_back(e);
    endtask

    // Scoreboard: one rising edge, then compare the oldest expectation.
    task automatic advance();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            if (we !== e.we) $display("FAIL sb_we: got %0b want %0b at %0t", we, e.we, $time);
            else n_pass++;
            n_checks++;
            if (locked !== e.locked) $display("FAIL sb_locked: got %0b want %0b at %0t", locked, e.locked, $time);
            else n_pass++;
            n_checks++;
            if (burst_err !== e.err) $display("FAIL sb_burst_err: got %0b want %0b at %0t", burst_err, e.err, $time);
            else n_pass++;
            if (e.chk_wr) begin
                n_checks++;
                if (waddr !== e.waddr) $display("FAIL sb_waddr: got %0d want %0d at %0t", waddr, e.waddr, $time);
                else n_pass++;
                n_checks++;
                if (wdata !== e.wdata) $display("FAIL sb_wdata: got %h want %h at %0t", wdata, e.wdata, $time);
                else n_pass++;
                n_checks++;
                if (owner !== e.owner) $display("FAIL sb_owner: got %0d want %0d at %0t", owner, e.owner, $time);
                else n_pass++;
            end
        end
    endtask

    task automatic idle(input logic lk);
        bus.req_valid = '0;
        push_exp(1'b0, 5'd0, 32'd0, 3'd0, lk, 1'b0, 1'b0);
        advance();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req_valid = '0;
        push_exp(1'b0, 5'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        advance();
        bus.req_valid = 3'b111;
        bus.req_last  = 3'b111;
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b000) $display("FAIL reset_ready: got %b want 000", bus.req_ready);
        else n_pass++;
        push_exp(1'b0, 5'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        advance();
        bus.req_valid = '0;
        rst = 1'b1;
    endtask

    task automatic test_single_alu();
        set_req(REQ_ALU, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b001) $display("FAIL alu_ready: got %b want 001", bus.req_ready);
        else n_pass++;
        push_exp(1'b1, 5'd5, 32'hDEADBEEF, 3'd0, 1'b0, 1'b0, 1'b1);
        advance();
        idle(1'b0);
    endtask

    task automatic test_round_robin();
        logic [2:0] want [4];
        want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100; want[3] = 3'b001;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + i, 1'b1);
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (bus.req_ready !== want[c]) $display("FAIL rr_ready%0d: got %b want %b", c, bus.req_ready, want[c]);
            else n_pass++;
            push_exp(1'b1, 5'((c % 3) + 1), 32'h100 + (c % 3), 3'(c % 3), 1'b0, 1'b0, 1'b1);
            advance();
        end
        idle(1'b0);
    endtask

    task automatic test_lock();
        // Pointer is at 1: the MDU wins over the ALU.
        set_req(REQ_ALU, 1'b1, 5'd3, 32'hA0, 1'b1);
        set_req(REQ_MDU, 1'b1, 5'd8, 32'h88, 1'b0);
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b100) $display("FAIL lock_beat1_ready: got %b want 100", bus.req_ready);
        else n_pass++;
        push_exp(1'b1, 5'd8, 32'h88, 3'd2, 1'b1, 1'b0, 1'b1);
        advance();
        // Owner idle: bubble, lock held, ALU still blocked.
        bus.req_valid[REQ_MDU] = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b000) $display("FAIL lock_bubble_ready: got %b want 000", bus.req_ready);
        else n_pass++;
        push_exp(1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        advance();
        set_req(REQ_MDU, 1'b1, 5'd9, 32'h99, 1'b1);
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b100) $display("FAIL lock_beat2_ready: got %b want 100", bus.req_ready);
        else n_pass++;
        push_exp(1'b1, 5'd9, 32'h99, 3'd2, 1'b0, 1'b0, 1'b1);
        advance();
        bus.req_valid[REQ_MDU] = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b001) $display("FAIL lock_alu_after: got %b want 001", bus.req_ready);
        else n_pass++;
        push_exp(1'b1, 5'd3, 32'hA0, 3'd0, 1'b0, 1'b0, 1'b1);
        advance();
        idle(1'b0);
    endtask

    task automatic test_reg_zero();
        set_req(REQ_LOAD, 1'b1, 5'd0, 32'h1234, 1'b1);
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b010) $display("FAIL zero_ready: got %b want 010", bus.req_ready);
        else n_pass++;
        push_exp(1'b0, 5'd0, 32'h1234, 3'd1, 1'b0, 1'b0, 1'b1);
        advance();
        // All valid: pointer must now sit at 2.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(20 + i), 32'h200 + i, 1'b1);
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b100) $display("FAIL zero_ptr_adv: got %b want 100", bus.req_ready);
        else n_pass++;
        push_exp(1'b1, 5'd22, 32'h202, 3'd2, 1'b0, 1'b0, 1'b1);
        advance();
        idle(1'b0);
    endtask

    task automatic test_burst_limit();
        bus.req_valid = '0;
        for (int b = 0; b < 4; b++) begin
            set_req(REQ_MDU, 1'b1, 5'(10 + b), 32'hB000 + b, 1'b0);
            if (b > 0) set_req(REQ_ALU, 1'b1, 5'd7, 32'h77, 1'b1);
            #1;
            n_checks++;
            if (bus.req_ready !== 3'b100) $display("FAIL burst_ready%0d: got %b want 100", b, bus.req_ready);
            else n_pass++;
            push_exp(1'b1, 5'(10 + b), 32'hB000 + b, 3'd2, (b < 3), (b == 3), 1'b1);
            advance();
        end
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b001) $display("FAIL burst_alu_next: got %b want 001", bus.req_ready);
        else n_pass++;
        push_exp(1'b1, 5'd7, 32'h77, 3'd0, 1'b0, 1'b0, 1'b1);
        advance();
        idle(1'b0);
    endtask

    task automatic test_reset_mid_burst();
        set_req(REQ_MDU, 1'b1, 5'd20, 32'hC0, 1'b0);
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b100) $display("FAIL rstmid_beat1: got %b want 100", bus.req_ready);
        else n_pass++;
        push_exp(1'b1, 5'd20, 32'hC0, 3'd2, 1'b1, 1'b0, 1'b1);
        advance();
        set_req(REQ_MDU, 1'b1, 5'd21, 32'hC1, 1'b0);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b000) $display("FAIL rstmid_ready: got %b want 000", bus.req_ready);
        else n_pass++;
        push_exp(1'b0, 5'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        advance();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(24 + i), 32'hD0 + i, 1'b1);
        #1;
        n_checks++;
        if (bus.req_ready !== 3'b001) $display("FAIL rstmid_first_grant: got %b want 001", bus.req_ready);
        else n_pass++;
        push_exp(1'b1, 5'd24, 32'hD0, 3'd0, 1'b0, 1'b0, 1'b1);
        advance();
        idle(1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;

        test_reset();
        test_single_alu();
        test_reset();
        test_round_robin();
        test_lock();
        test_reg_zero();
        test_burst_limit();
        test_reset_mid_burst();

        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_drain: got %0d want 0 pending", sb.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
